vga_timing_gen: RTL and testbench

Parametrised VGA raster timing generator. It produces the horizontal and vertical counters, both sync pulses, the display-enable, active-area pixel coordinates and frame/line strobes from one clock gated by a pixel-enable tick. It replaces the per-axis combinational display decoders and feeds the sprite renderer and the RGB output stage directly. Defaults give 640x480@60 (800x525 total).

---
 rtl/vga_timing_pkg.sv | 18 +
 rtl/vga_axis_counter.sv | 53 +++++
 rtl/vga_timing_gen.sv | 63 ++++++
 tb/tb_vga_timing_gen.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 640x480@60 default timing, per-axis region type and total-length helper.
package vga_timing_pkg;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_CW       = 10;

    typedef enum logic [1:0] {SYNC, BACK_PORCH, ACTIVE, FRONT_PORCH} region_t;

    function automatic int axis_total(input int sync_len, input int bp_len, input int act_len, input int fp_len);
        return sync_len + bp_len + act_len + fp_len;
    endfunction
endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one raster axis; counter, wrap flag, region decode, sync bit and active offset.
// Decode looks at the count the register will hold after this edge, so outputs stay aligned with cnt.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int SYNC_LEN = DEF_H_SYNC,
    parameter int BP_LEN   = DEF_H_BP,
    parameter int ACT_LEN  = DEF_H_ACTIVE,
    parameter int FP_LEN   = DEF_H_FP,
    parameter bit POL      = 1'b0,
    parameter int CW       = DEF_CW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          adv,
    output logic [CW-1:0] cnt,
    output logic          sync,
    output logic          last,
    output logic          n_act,
    output logic [CW-1:0] n_off
);
    localparam int TOTAL = axis_total(SYNC_LEN, BP_LEN, ACT_LEN, FP_LEN);
    localparam logic [CW-1:0] BP_AT   = CW'(SYNC_LEN);
    localparam logic [CW-1:0] ACT_AT  = CW'(SYNC_LEN + BP_LEN);
    localparam logic [CW-1:0] FP_AT   = CW'(SYNC_LEN + BP_LEN + ACT_LEN);
    localparam logic [CW-1:0] LAST_AT = CW'(TOTAL - 1);

    if (SYNC_LEN < 1 || BP_LEN < 1 || ACT_LEN < 1 || FP_LEN < 1 || CW < 1 || CW > 30 || TOTAL > (1 << CW)) begin : g_bad_cfg
        $error("vga_axis_counter: zero-width region or total exceeds counter range");
    end

    logic [CW-1:0] cnt_d;
    region_t       region;

    assign last = cnt == LAST_AT;

    always_comb begin
        cnt_d  = adv ? (last ? '0 : cnt + 1'b1) : cnt;
        region = cnt_d < BP_AT ? SYNC : cnt_d < ACT_AT ? BACK_PORCH : cnt_d < FP_AT ? ACTIVE : FRONT_PORCH;
        n_act  = region == ACTIVE;
        n_off  = n_act ? cnt_d - ACT_AT : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            sync <= POL;
        end else begin
            cnt  <= cnt_d;
            sync <= region == SYNC ? POL : ~POL;
        end
    end
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing; counters, syncs, display enable, active coordinates and strobes.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BP      = DEF_H_BP,
    parameter int H_ACTIVE  = DEF_H_ACTIVE,
    parameter int H_FP      = DEF_H_FP,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BP      = DEF_V_BP,
    parameter int V_ACTIVE  = DEF_V_ACTIVE,
    parameter int V_FP      = DEF_V_FP,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0,
    parameter int CW        = DEF_CW
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          pix_en,
    output logic [CW-1:0] H_Counts,
    output logic [CW-1:0] V_Counts,
    output logic          HSYNC,
    output logic          VSYNC,
    output logic          display,
    output logic [CW-1:0] Display_Col,
    output logic [CW-1:0] Display_Row,
    output logic          line_start,
    output logic          frame_start
);
    logic          h_last, v_last, h_act, v_act;
    logic [CW-1:0] h_off, v_off;

    vga_axis_counter #(
        .SYNC_LEN(H_SYNC), .BP_LEN(H_BP), .ACT_LEN(H_ACTIVE), .FP_LEN(H_FP), .POL(HSYNC_POL), .CW(CW)
    ) u_h (
        .clk(CLK), .rst(RESET), .adv(pix_en), .cnt(H_Counts), .sync(HSYNC),
        .last(h_last), .n_act(h_act), .n_off(h_off)
    );

    // The vertical axis only steps on the tick that wraps the horizontal one.
    vga_axis_counter #(
        .SYNC_LEN(V_SYNC), .BP_LEN(V_BP), .ACT_LEN(V_ACTIVE), .FP_LEN(V_FP), .POL(VSYNC_POL), .CW(CW)
    ) u_v (
        .clk(CLK), .rst(RESET), .adv(pix_en & h_last), .cnt(V_Counts), .sync(VSYNC),
        .last(v_last), .n_act(v_act), .n_off(v_off)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            display     <= 1'b0;
            Display_Col <= '0;
            Display_Row <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (pix_en) begin
            display     <= h_act & v_act;
            Display_Col <= (h_act & v_act) ? h_off : '0;
            Display_Row <= (h_act & v_act) ? v_off : '0;
            line_start  <= h_last;
            frame_start <= h_last & v_last;
        end
    end
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: default 640x480 instance and a small positive-polarity instance
// driven by the same pix_en/RESET and compared to a tick-count raster model.
module tb_vga_timing_gen;
    logic clk = 1'b0, rst = 1'b1, pix_en = 1'b0;
    logic [9:0] h0, v0, col0, row0;
    logic hs0, vs0, de0, ls0, fs0;
    logic [4:0] h1, v1, col1, row1;
    logic hs1, vs1, de1, ls1, fs1;

    typedef struct packed {
        logic [9:0] h, v;
        logic hs, vs, de;
        logic [9:0] col, row;
        logic ls, fs;
    } obs_t;
    typedef struct { int n; obs_t exp; } vec_t;

    int n, errors, checks, last_fs, ls_clks;
    vec_t tbl[$];
    obs_t o0, o1;

    assign o0 = {h0, v0, hs0, vs0, de0, col0, row0, ls0, fs0};
    assign o1 = {5'd0, h1, 5'd0, v1, hs1, vs1, de1, 5'd0, col1, 5'd0, row1, ls1, fs1};

    always #5 clk = ~clk;

    vga_timing_gen dut0 (
        .CLK(clk), .RESET(rst), .pix_en(pix_en), .H_Counts(h0), .V_Counts(v0), .HSYNC(hs0), .VSYNC(vs0),
        .display(de0), .Display_Col(col0), .Display_Row(row0), .line_start(ls0), .frame_start(fs0)
    );

    vga_timing_gen #(
        .H_SYNC(8), .H_BP(4), .H_ACTIVE(16), .H_FP(4), .V_SYNC(2), .V_BP(3), .V_ACTIVE(6), .V_FP(2),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .CW(5)
    ) dut1 (
        .CLK(clk), .RESET(rst), .pix_en(pix_en), .H_Counts(h1), .V_Counts(v1), .HSYNC(hs1), .VSYNC(vs1),
        .display(de1), .Display_Col(col1), .Display_Row(row1), .line_start(ls1), .frame_start(fs1)
    );

    // Raster position follows directly from the number of ticks since reset.
    function automatic obs_t model(int t, int hs, int hb, int ha, int hf, int vs, int vb, int va, int vf, bit hp, bit vp);
        int ht = hs + hb + ha + hf;
        int vt = vs + vb + va + vf;
        int h = t % ht;
        int v = (t / ht) % vt;
        bit dh = h >= hs + hb && h < hs + hb + ha;
        bit dv = v >= vs + vb && v < vs + vb + va;
        obs_t o;
        o.h = 10'(h);
        o.v = 10'(v);
        o.hs = h < hs ? hp : !hp;
        o.vs = v < vs ? vp : !vp;
        o.de = dh && dv;
        o.col = o.de ? 10'(h - hs - hb) : 10'd0;
        o.row = o.de ? 10'(v - vs - vb) : 10'd0;
        o.ls = t > 0 && h == 0;
        o.fs = o.ls && v == 0;
        return o;
    endfunction

    function automatic obs_t m0();
        return model(n, 96, 48, 640, 16, 2, 33, 480, 10, 1'b0, 1'b0);
    endfunction

    function automatic obs_t m1();
        return model(n, 8, 4, 16, 4, 2, 3, 6, 2, 1'b1, 1'b1);
    endfunction

    function automatic obs_t mk(int h, int v, bit hs, bit vs, bit de, int col, int row, bit ls, bit fs);
        obs_t o;
        o.h = 10'(h); o.v = 10'(v); o.hs = hs; o.vs = vs; o.de = de;
        o.col = 10'(col); o.row = 10'(row); o.ls = ls; o.fs = fs;
        return o;
    endfunction

    function automatic string fmt(obs_t o);
        return $sformatf("h=%0d v=%0d hs=%0b vs=%0b de=%0b col=%0d row=%0d ls=%0b fs=%0b",
                         o.h, o.v, o.hs, o.vs, o.de, o.col, o.row, o.ls, o.fs);
    endfunction

    task automatic check(string name, obs_t got, obs_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s tick=%0d got {%s} want {%s}", name, n, fmt(got), fmt(exp));
        end
    endtask

    task automatic check_int(string name, int got, int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s tick=%0d got %0d want %0d", name, n, got, exp);
        end
    endtask

    task automatic add(int t, obs_t e);
        vec_t r;
        r.n = t;
        r.exp = e;
        tbl.push_back(r);
    endtask

    task automatic step(bit en);
        pix_en = en;
        @(posedge clk);
        #1;
        if (en) n++;
        check("model_default", o0, m0());
        check("model_small", o1, m1());
        if (en && fs1) begin
            if (last_fs >= 0) check_int("frame_ticks", n - last_fs, 416);
            check_int("frame_with_line", int'(ls1), 1);
            last_fs = n;
        end
    endtask

    initial begin
        errors = 0; checks = 0; n = 0; last_fs = -1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_default", o0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        check("reset_small", o1, mk(0, 0, 1, 1, 0, 0, 0, 0, 0));
        rst = 1'b0;

        add(1,     mk(1,   0,  0, 0, 0, 0,   0, 0, 0));
        add(95,    mk(95,  0,  0, 0, 0, 0,   0, 0, 0));
        add(96,    mk(96,  0,  1, 0, 0, 0,   0, 0, 0));
        add(799,   mk(799, 0,  1, 0, 0, 0,   0, 0, 0));
        add(800,   mk(0,   1,  0, 0, 0, 0,   0, 1, 0));
        add(801,   mk(1,   1,  0, 0, 0, 0,   0, 0, 0));
        add(1600,  mk(0,   2,  0, 1, 0, 0,   0, 1, 0));
        add(28143, mk(143, 35, 1, 1, 0, 0,   0, 0, 0));
        add(28144, mk(144, 35, 1, 1, 1, 0,   0, 0, 0));
        add(28783, mk(783, 35, 1, 1, 1, 639, 0, 0, 0));
        add(28784, mk(784, 35, 1, 1, 0, 0,   0, 0, 0));
        add(28944, mk(144, 36, 1, 1, 1, 0,   1, 0, 0));
        foreach (tbl[i]) begin
            while (n < tbl[i].n) step(1'b1);
            check($sformatf("vec%0d", i), o0, tbl[i].exp);
        end

        while (n < 29583) step(1'b1);
        check("pre_freeze", o0, mk(783, 36, 1, 1, 1, 639, 1, 0, 0));
        repeat (50) begin
            step(1'b0);
            check("frozen", o0, mk(783, 36, 1, 1, 1, 639, 1, 0, 0));
        end
        step(1'b1);
        check("post_freeze", o0, mk(784, 36, 1, 1, 0, 0, 1 - 1, 0, 0));

        ls_clks = 0;
        repeat (40) begin
            step(1'b1);
            ls_clks += int'(ls0);
            step(1'b0);
            ls_clks += int'(ls0);
        end
        check_int("line_start_clks", ls_clks, 2);

        repeat (3000) step($urandom_range(0, 2) != 0);

        while (n % 800 != 300) step(1'b1);
        #2 rst = 1'b1;
        #1;
        n = 0;
        last_fs = -1;
        check("async_reset_default", o0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        check("async_reset_small", o1, mk(0, 0, 1, 1, 0, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        check("reset_held", o0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        rst = 1'b0;
        step(1'b1);
        check("first_tick_default", o0, mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
        check("first_tick_small", o1, mk(1, 0, 1, 1, 0, 0, 0, 0, 0));
        repeat (900) step(1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
